// File: rtl/demux_sel_scheduler.sv
// Round-robin scheduler feeding the 1-to-4 demux: grants one requesting channel
// for a fixed dwell, gates din onto w during the dwell, and inserts an idle gap.
module demux_sel_scheduler #(
    parameter int DWELL = 10,
    parameter int GAP   = 1,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       din,
    output logic [1:0] sel,
    output logic       w,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DWELL,
        ST_GAP
    } state_t;

    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP > 0) ? (GAP - 1) : 0);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    ptr, ptr_n;
    logic [1:0]    sel_n;
    logic [3:0]    grant_n;
    logic          busy_n;
    logic          done_n;

    logic [1:0]    base;
    logic [1:0]    idx;
    logic [1:0]    winner;
    logic          found;
    logic          decide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            grant <= 4'b0000;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            grant <= grant_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // A back-to-back decision at the end of a dwell must already see the advanced pointer.
    always_comb begin
        base   = (state == ST_DWELL) ? sel + 2'd1 : ptr;
        found  = 1'b0;
        winner = base;
        idx    = base;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        sel_n   = sel;
        done_n  = 1'b0;
        decide  = 1'b0;

        case (state)
            ST_IDLE: begin
                decide = 1'b1;
            end
            ST_DWELL: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    done_n = 1'b1;
                    ptr_n  = sel + 2'd1;
                    if (GAP > 0) begin
                        state_n = ST_GAP;
                        cnt_n   = GAP_LOAD;
                    end else begin
                        state_n = ST_IDLE;
                        decide  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = ST_IDLE;
                    decide  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        if (decide && en && found) begin
            state_n = ST_DWELL;
            sel_n   = winner;
            cnt_n   = DWELL_LOAD;
        end

        grant_n = (state_n == ST_DWELL) ? (4'b0001 << sel_n) : 4'b0000;
        busy_n  = (state_n != ST_IDLE);
    end

    assign w = din & (state == ST_DWELL);

endmodule

// File: tb/tb_demux_sel_scheduler.sv
// Directed bench for demux_sel_scheduler: one instance with a one-cycle gap and
// one with no gap, checked against hand-computed output vectors.
module tb_demux_sel_scheduler;

    logic       clk;
    logic       rst_n;
    logic       en, din;
    logic [3:0] req;
    logic [1:0] sel;
    logic       w, busy, done;
    logic [3:0] grant;

    logic       en_b, din_b;
    logic [3:0] req_b;
    logic [1:0] sel_b;
    logic       w_b, busy_b, done_b;
    logic [3:0] grant_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         adv;
        logic       en;
        logic [3:0] req;
        logic       din;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       busy;
        logic       done;
        logic       w;
    } vec_t;

    vec_t tbl[14];

    demux_sel_scheduler #(.DWELL(10), .GAP(1), .CW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .din(din),
        .sel(sel), .w(w), .grant(grant), .busy(busy), .done(done)
    );

    demux_sel_scheduler #(.DWELL(10), .GAP(0), .CW(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .req(req_b), .din(din_b),
        .sel(sel_b), .w(w_b), .grant(grant_b), .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Packed vector layout: {sel[1:0], grant[3:0], busy, done, w}
    task automatic check_output(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got sel=%0d grant=%b busy=%b done=%b w=%b, want sel=%0d grant=%b busy=%b done=%b w=%b",
                     name, act[8:7], act[6:3], act[2], act[1], act[0],
                     exp[8:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_a(input string name, input logic [1:0] s, input logic [3:0] g,
                           input logic b, input logic d, input logic ww);
        check_output(name, {sel, grant, busy, done, w}, {s, g, b, d, ww});
    endtask

    task automatic check_b(input string name, input logic [1:0] s, input logic [3:0] g,
                           input logic b, input logic d, input logic ww);
        check_output(name, {sel_b, grant_b, busy_b, done_b, w_b}, {s, g, b, d, ww});
    endtask

    task automatic apply_stimulus(input logic e, input logic [3:0] r, input logic d);
        en  = e;
        req = r;
        din = d;
    endtask

    initial begin
        tbl[0]  = '{3, 1'b1, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1, 1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{8, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{9, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{5, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{9, 1'b1, 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1, 1'b1, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1, 1'b1, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b1;
        apply_stimulus(1'b0, 4'b0000, 1'b1);
        en_b  = 1'b0;
        req_b = 4'b0000;
        din_b = 1'b1;

        // Reset takes effect between clock edges
        #3 rst_n = 1'b0;
        #1 check_a("reset_async", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_b("reset_async_b", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(tbl[i].en, tbl[i].req, tbl[i].din);
            repeat (tbl[i].adv) @(negedge clk);
            check_a($sformatf("row%0d", i), tbl[i].sel, tbl[i].grant,
                    tbl[i].busy, tbl[i].done, tbl[i].w);
        end

        // Reset in the middle of a dwell
        apply_stimulus(1'b1, 4'b0100, 1'b1);
        @(negedge clk);
        check_a("pre_reset_dwell", 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_a("reset_mid_dwell", 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Full load from reset: 0,1,2,3,0 with one gap cycle between grants
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 4'b1111, 1'b1);
        for (int g = 0; g < 5; g++) begin
            logic [1:0] ch;
            ch = 2'(g % 4);
            @(negedge clk);
            check_a($sformatf("full_start%0d", g), ch, 4'b0001 << ch, 1'b1, 1'b0, 1'b1);
            repeat (9) @(negedge clk);
            check_a($sformatf("full_last%0d", g), ch, 4'b0001 << ch, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            check_a($sformatf("full_gap%0d", g), ch, 4'b0000, 1'b1, 1'b1, 1'b0);
        end

        // Fairness: once channel 1 finishes, channel 0 beats channel 1
        @(negedge clk);
        check_a("fair_ch1", 2'd1, 4'b0010, 1'b1, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        apply_stimulus(1'b1, 4'b0011, 1'b1);
        @(negedge clk);
        check_a("fair_gap", 2'd1, 4'b0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_a("fair_ch0", 2'd0, 4'b0001, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 4'b0000, 1'b0);

        // No-gap instance: back-to-back grants 1 then 3
        en_b  = 1'b1;
        req_b = 4'b1010;
        din_b = 1'b1;
        @(negedge clk);
        check_b("b2b_first", 2'd1, 4'b0010, 1'b1, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        check_b("b2b_last", 2'd1, 4'b0010, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check_b("b2b_switch", 2'd3, 4'b1000, 1'b1, 1'b1, 1'b1);
        en_b = 1'b0;
        @(negedge clk);
        check_b("b2b_second", 2'd3, 4'b1000, 1'b1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        check_b("b2b_second_last", 2'd3, 4'b1000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check_b("b2b_idle", 2'd3, 4'b0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_b("b2b_idle_hold", 2'd3, 4'b0000, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
